// File: rtl/seq_mult.sv
// seq_mult: sequential shift-add multiplier with a Start/Ready/Busy/Done handshake.
// Each multiplier bit costs one SHIFT cycle, plus one ADD/SUB cycle if the bit is set.
// The registered Product holds the last completed result until the next one is ready.
//
// Build option: define SEQMULT_SIGNED_EN for two's-complement operands. In that mode
// the add is sign-extended, the final multiplier bit is handled by a SUB step, and the
// shift is arithmetic. Without it the operands are unsigned, X holds the carry-out,
// and SUB is never entered.
//
// Ports:
//   Clk      in   system clock, rising edge
//   Reset    in   synchronous, active-high reset
//   Start    in   level request, sampled only in IDLE
//   A_in     in   WIDTH-bit multiplicand, captured when Start is accepted
//   B_in     in   WIDTH-bit multiplier, captured when Start is accepted
//   Ready    out  high only in IDLE
//   Busy     out  high in ADD, SUB and SHIFT
//   Done     out  one-cycle pulse in DONE
//   Product  out  2*WIDTH-bit result of the last completed multiply
module seq_mult #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic [WIDTH-1:0]     A_in,
    input  logic [WIDTH-1:0]     B_in,
    output logic                 Ready,
    output logic                 Busy,
    output logic                 Done,
    output logic [2*WIDTH-1:0]   Product
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_PENULT = CNT_W'(WIDTH - 2);

`ifdef SEQMULT_SIGNED_EN
    localparam bit SIGNED_MODE = 1'b1;
`else
    localparam bit SIGNED_MODE = 1'b0;
`endif

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADD   = 3'd1,
        ST_SUB   = 3'd2,
        ST_SHIFT = 3'd3,
        ST_DONE  = 3'd4,
        ST_WAIT  = 3'd5
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [WIDTH-1:0]   s_q;
    logic               x_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2*WIDTH-1:0] p_q;

    logic ready_d;
    logic busy_d;
    logic done_d;

    // Operands widened by one bit: sign extension in signed mode, zero (carry room) otherwise.
    logic [WIDTH:0] ext_a;
    logic [WIDTH:0] ext_s;
    logic [WIDTH:0] add_res;
    logic [WIDTH:0] sub_res;

    assign ext_a   = {(SIGNED_MODE & a_q[WIDTH-1]), a_q};
    assign ext_s   = {(SIGNED_MODE & s_q[WIDTH-1]), s_q};
    assign add_res = ext_a + ext_s;
    assign sub_res = ext_a - ext_s;

    // State register; the handshake outputs are registered alongside it.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            Ready   <= 1'b1;
            Busy    <= 1'b0;
            Done    <= 1'b0;
        end else begin
            state_q <= state_d;
            Ready   <= ready_d;
            Busy    <= busy_d;
            Done    <= done_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                // Bit 0 is never the last bit since WIDTH >= 2, so a set bit 0 always adds.
                if (Start) begin
                    state_d = B_in[0] ? ST_ADD : ST_SHIFT;
                end
            end
            ST_ADD:   state_d = ST_SHIFT;
            ST_SUB:   state_d = ST_SHIFT;
            ST_SHIFT: begin
                // b_q[1] is the multiplier bit that the shift moves into position 0.
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                end else if (b_q[1]) begin
                    state_d = (SIGNED_MODE && (cnt_q == CNT_PENULT)) ? ST_SUB : ST_ADD;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE:  state_d = ST_WAIT;
            ST_WAIT: begin
                if (!Start) begin
                    state_d = ST_IDLE;
                end
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output decode of the upcoming state, so the outputs are registered with it.
    always_comb begin
        ready_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_d)
            ST_IDLE:                   ready_d = 1'b1;
            ST_ADD, ST_SUB, ST_SHIFT:  busy_d  = 1'b1;
            ST_DONE:                   done_d  = 1'b1;
            default: ;
        endcase
    end

    // Datapath: operand capture, accumulate, shift and product latch.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            s_q   <= '0;
            x_q   <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            cnt_q <= '0;
            p_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (Start) begin
                        s_q   <= A_in;
                        b_q   <= B_in;
                        a_q   <= '0;
                        x_q   <= 1'b0;
                        cnt_q <= '0;
                    end
                end
                ST_ADD: begin
                    x_q <= add_res[WIDTH];
                    a_q <= add_res[WIDTH-1:0];
                end
                ST_SUB: begin
                    x_q <= sub_res[WIDTH];
                    a_q <= sub_res[WIDTH-1:0];
                end
                ST_SHIFT: begin
                    // {X,A,B} >> 1; X is replicated in signed mode, cleared otherwise.
                    x_q   <= SIGNED_MODE & x_q;
                    a_q   <= {x_q, a_q[WIDTH-1:1]};
                    b_q   <= {a_q[0], b_q[WIDTH-1:1]};
                    cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
                end
                ST_DONE: begin
                    p_q <= {a_q, b_q};
                end
                default: ;
            endcase
        end
    end

    assign Product = p_q;

endmodule

// File: tb/tb_seq_mult.sv
module tb_seq_mult;

    localparam int unsigned W = 8;

    logic           Clk = 1'b0;
    logic           Reset;
    logic           Start;
    logic [W-1:0]   A_in;
    logic [W-1:0]   B_in;
    logic           Ready;
    logic           Busy;
    logic           Done;
    logic [2*W-1:0] Product;

    int n_tests = 0;
    int n_fail  = 0;

    logic [2*W-1:0] sb_q[$];

    seq_mult #(.WIDTH(W)) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .Start   (Start),
        .A_in    (A_in),
        .B_in    (B_in),
        .Ready   (Ready),
        .Busy    (Busy),
        .Done    (Done),
        .Product (Product)
    );

    always #5 Clk = ~Clk;

    // Reference product in the build's arithmetic mode.
    function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] ea;
        logic [2*W-1:0] eb;
`ifdef SEQMULT_SIGNED_EN
        ea = {{W{a[W-1]}}, a};
        eb = {{W{b[W-1]}}, b};
`else
        ea = {{W{1'b0}}, a};
        eb = {{W{1'b0}}, b};
`endif
        return ea * eb;
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Drives one multiply from the post-edge phase and records what the DUT does.
    // On return the TB is one cycle past the Done pulse (FSM expected in WAIT).
    task automatic do_mult(input logic [W-1:0] a, input logic [W-1:0] b, input bit hold,
                           output int busy_cyc, output int done_cyc,
                           output logic [2*W-1:0] prod, output bit wait_ok,
                           output bit timeout);
        sb_q.push_back(model(a, b));
        A_in  = a;
        B_in  = b;
        Start = 1'b1;
        tick();
        if (!hold) Start = 1'b0;
        A_in = ~a;
        B_in = ~b;
        busy_cyc = 0;
        done_cyc = 0;
        timeout  = 1'b1;
        for (int c = 0; c < 200; c++) begin
            if (Busy) busy_cyc++;
            if (Done) begin
                done_cyc++;
                timeout = 1'b0;
                break;
            end
            tick();
        end
        tick();
        prod    = Product;
        wait_ok = !Ready && !Busy && !Done;
        if (Done) done_cyc++;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        Start = 1'b1;
        A_in  = 8'h11;
        B_in  = 8'h01;
        tick();
        tick();
        n_tests++;
        if (Ready !== 1'b1 || Busy !== 1'b0 || Done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: Ready=%b Busy=%b Done=%b, want 1 0 0", Ready, Busy, Done);
        end
        n_tests++;
        if (Product !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_product: got %h want 0000", Product);
        end
        Reset = 1'b0;
        Start = 1'b0;
        tick();
        n_tests++;
        if (Ready !== 1'b1 || Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: Ready=%b Busy=%b want 1 0", Ready, Busy);
        end
    endtask

    task automatic test_basic();
        int busy_cyc, done_cyc;
        logic [2*W-1:0] prod, exp_p;
        bit wait_ok, timeout;
        do_mult(8'h07, 8'hFD, 1'b0, busy_cyc, done_cyc, prod, wait_ok, timeout);
        exp_p = sb_q.pop_front();
        n_tests++;
        if (timeout) begin
            n_fail++;
            $display("FAIL basic_timeout: no Done within budget");
        end
        n_tests++;
        if (busy_cyc != 15) begin
            n_fail++;
            $display("FAIL basic_busy: got %0d cycles want 15", busy_cyc);
        end
        n_tests++;
        if (done_cyc != 1) begin
            n_fail++;
            $display("FAIL basic_done_pulse: got %0d cycles want 1", done_cyc);
        end
        n_tests++;
        if (prod !== exp_p) begin
            n_fail++;
            $display("FAIL basic_product: got %h want %h", prod, exp_p);
        end
        n_tests++;
        if (!wait_ok) begin
            n_fail++;
            $display("FAIL basic_post_done: Ready=%b Busy=%b Done=%b want 0 0 0", Ready, Busy, Done);
        end
        tick();
        n_tests++;
        if (Ready !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_ready_return: got %b want 1", Ready);
        end
    endtask

    // Table of corner operands followed by random ones, all checked against the scoreboard.
    task automatic test_patterns();
        logic [W-1:0] ta[4];
        logic [W-1:0] tb[4];
        ta = '{8'h80, 8'hFF, 8'h5A, 8'h01};
        tb = '{8'h80, 8'hFF, 8'h00, 8'h7F};
        for (int i = 0; i < 24; i++) begin
            logic [W-1:0] a, b;
            int busy_cyc, done_cyc, want_busy;
            logic [2*W-1:0] prod, exp_p;
            bit wait_ok, timeout;
            if (i < 4) begin
                a = ta[i];
                b = tb[i];
            end else begin
                a = W'($urandom_range(0, 255));
                b = W'($urandom_range(0, 255));
            end
            want_busy = W + $countones(b);
            do_mult(a, b, 1'b0, busy_cyc, done_cyc, prod, wait_ok, timeout);
            exp_p = sb_q.pop_front();
            n_tests++;
            if (timeout || busy_cyc != want_busy || done_cyc != 1) begin
                n_fail++;
                $display("FAIL pat%0d_timing: %h*%h busy=%0d done=%0d timeout=%b want busy=%0d done=1",
                         i, a, b, busy_cyc, done_cyc, timeout, want_busy);
            end
            n_tests++;
            if (prod !== exp_p) begin
                n_fail++;
                $display("FAIL pat%0d_product: %h*%h got %h want %h", i, a, b, prod, exp_p);
            end
            tick();
            n_tests++;
            if (Ready !== 1'b1 || Product !== exp_p) begin
                n_fail++;
                $display("FAIL pat%0d_hold: Ready=%b Product=%h want 1 %h", i, Ready, Product, exp_p);
            end
        end
    endtask

    task automatic test_held_start();
        int busy_cyc, done_cyc, extra_done;
        logic [2*W-1:0] prod, exp_p;
        bit wait_ok, timeout;
        do_mult(8'h12, 8'h34, 1'b1, busy_cyc, done_cyc, prod, wait_ok, timeout);
        exp_p = sb_q.pop_front();
        extra_done = 0;
        for (int c = 0; c < 20; c++) begin
            if (Done || Busy || Ready) extra_done++;
            tick();
        end
        n_tests++;
        if (timeout || done_cyc != 1 || extra_done != 0 || prod !== exp_p) begin
            n_fail++;
            $display("FAIL held_start: done=%0d timeout=%b stray=%0d prod=%h want done=1 stray=0 prod=%h",
                     done_cyc, timeout, extra_done, prod, exp_p);
        end
        Start = 1'b0;
        tick();
        n_tests++;
        if (Ready !== 1'b1) begin
            n_fail++;
            $display("FAIL held_release: Ready got %b want 1", Ready);
        end
        do_mult(8'h03, 8'h04, 1'b0, busy_cyc, done_cyc, prod, wait_ok, timeout);
        exp_p = sb_q.pop_front();
        n_tests++;
        if (prod !== 16'h000C || prod !== exp_p || done_cyc != 1) begin
            n_fail++;
            $display("FAIL back_to_back: got %h done=%0d want 000c done=1", prod, done_cyc);
        end
        tick();
    endtask

    task automatic test_mid_reset();
        int dones;
        A_in  = 8'h07;
        B_in  = 8'hFD;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        for (int c = 1; c < 5; c++) tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        n_tests++;
        if (Ready !== 1'b1 || Busy !== 1'b0 || Done !== 1'b0 || Product !== 16'h0000) begin
            n_fail++;
            $display("FAIL mid_reset: Ready=%b Busy=%b Done=%b Product=%h want 1 0 0 0000",
                     Ready, Busy, Done, Product);
        end
        dones = 0;
        for (int c = 0; c < 30; c++) begin
            if (Done || !Ready) dones++;
            tick();
        end
        n_tests++;
        if (dones != 0) begin
            n_fail++;
            $display("FAIL mid_reset_no_done: %0d non-idle cycles want 0", dones);
        end
    endtask

    initial begin
        Reset = 1'b1;
        Start = 1'b0;
        A_in  = '0;
        B_in  = '0;
        test_reset();
        test_basic();
        test_patterns();
        test_held_start();
        test_mid_reset();
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: %0d entries left want 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
